// File: rtl/cpu_isa_pkg.sv
// ---------------------------------------------------------------------------
// cpu_isa_pkg
// Shared MIPS ISA definitions for the instruction decoder and the
// instruction encoder/loader: instruction formats, opcode and funct
// constants, field bit positions, a legality helper, and the loader FSM
// state type.
// ---------------------------------------------------------------------------
package cpu_isa_pkg;

   // Instruction format carried alongside each field record.
   typedef enum logic [1:0] {
      FMT_R   = 2'd0,
      FMT_I   = 2'd1,
      FMT_J   = 2'd2,
      FMT_BAD = 2'd3
   } fmt_t;

   // Opcodes
   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_J       = 6'h02;
   localparam logic [5:0] OP_JAL     = 6'h03;
   localparam logic [5:0] OP_BEQ     = 6'h04;
   localparam logic [5:0] OP_BNE     = 6'h05;
   localparam logic [5:0] OP_ADDI    = 6'h08;
   localparam logic [5:0] OP_ADDIU   = 6'h09;
   localparam logic [5:0] OP_SLTI    = 6'h0A;
   localparam logic [5:0] OP_ANDI    = 6'h0C;
   localparam logic [5:0] OP_ORI     = 6'h0D;
   localparam logic [5:0] OP_LUI     = 6'h0F;
   localparam logic [5:0] OP_LW      = 6'h23;
   localparam logic [5:0] OP_SW      = 6'h2B;

   // R-type function codes
   localparam logic [5:0] FN_SLL = 6'h00;
   localparam logic [5:0] FN_SRL = 6'h02;
   localparam logic [5:0] FN_JR  = 6'h08;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   // Field least-significant bit positions within the 32-bit word
   localparam int OP_LSB    = 26;
   localparam int RS_LSB    = 21;
   localparam int RT_LSB    = 16;
   localparam int RD_LSB    = 11;
   localparam int SHAMT_LSB = 6;
   localparam int FUNCT_LSB = 0;

   // Loader FSM states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2,
      ST_ERR  = 2'd3
   } load_state_t;

   // A format/opcode pair is legal when the opcode belongs to that format:
   // SPECIAL for R, J/JAL for J, anything else for I.
   function automatic logic fmt_legal(input fmt_t fmt, input logic [5:0] op);
      logic ok;
      ok = 1'b0;
      case (fmt)
         FMT_R:   ok = (op == OP_SPECIAL);
         FMT_J:   ok = (op == OP_J) || (op == OP_JAL);
         FMT_I:   ok = !((op == OP_SPECIAL) || (op == OP_J) || (op == OP_JAL));
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/instr_encoder_loader_if.sv
// ---------------------------------------------------------------------------
// instr_encoder_loader_if
// Field-record stream into the instruction encoder/loader.
//   in_valid / in_ready : handshake
//   in_fmt              : 0=R 1=I 2=J 3=illegal
//   in_op, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm, in_addr : fields
//   in_last             : record is the final word of the program
//
// Handshake: a record transfers on every rising clock edge where
// in_valid and in_ready are both 1. The master holds the record stable
// while in_valid=1 and in_ready=0; in_ready does not depend on in_valid.
// ---------------------------------------------------------------------------
interface instr_encoder_loader_if;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_fmt;
   logic [5:0]  in_op;
   logic [4:0]  in_rs;
   logic [4:0]  in_rt;
   logic [4:0]  in_rd;
   logic [4:0]  in_shamt;
   logic [5:0]  in_funct;
   logic [15:0] in_imm;
   logic [25:0] in_addr;
   logic        in_last;

   modport master (
      output in_valid, in_fmt, in_op, in_rs, in_rt, in_rd, in_shamt,
             in_funct, in_imm, in_addr, in_last,
      input  in_ready
   );

   modport slave (
      input  in_valid, in_fmt, in_op, in_rs, in_rt, in_rd, in_shamt,
             in_funct, in_imm, in_addr, in_last,
      output in_ready
   );
endinterface

// File: rtl/instr_pack.sv
// ---------------------------------------------------------------------------
// instr_pack
// Combinational packer: instruction fields + format -> 32-bit word, plus a
// legality flag for the format/opcode combination.
//   fmt, op, rs, rt, rd, shamt, funct, imm, addr : inputs
//   word  : packed instruction (0 for an illegal format)
//   legal : 1 when the format/opcode pair may be written
// ---------------------------------------------------------------------------
module instr_pack
   import cpu_isa_pkg::*;
(
   input  fmt_t        fmt,
   input  logic [5:0]  op,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [4:0]  shamt,
   input  logic [5:0]  funct,
   input  logic [15:0] imm,
   input  logic [25:0] addr,
   output logic [31:0] word,
   output logic        legal
);

   always_comb begin
      word = 32'h0;
      case (fmt)
         FMT_R: begin
            word[OP_LSB    +: 6] = op;
            word[RS_LSB    +: 5] = rs;
            word[RT_LSB    +: 5] = rt;
            word[RD_LSB    +: 5] = rd;
            word[SHAMT_LSB +: 5] = shamt;
            word[FUNCT_LSB +: 6] = funct;
         end
         FMT_I: begin
            word[OP_LSB +: 6] = op;
            word[RS_LSB +: 5] = rs;
            word[RT_LSB +: 5] = rt;
            word[15:0]        = imm;
         end
         FMT_J: begin
            word[OP_LSB +: 6] = op;
            word[25:0]        = addr;
         end
         default: word = 32'h0;
      endcase
   end

   assign legal = fmt_legal(fmt, op);

endmodule

// File: rtl/instr_encoder_loader.sv
// ---------------------------------------------------------------------------
// instr_encoder_loader
// Accepts MIPS field records, packs them into R/I/J words and writes them to
// instruction memory at consecutive word addresses starting at BASE_ADDR.
// Optional running XOR checksum of written words under ENC_CHECKSUM_EN.
//
// Ports
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : pulse; from IDLE/ERR clears err, rewinds address, loads
//   rec          : field-record stream (slave side)
//   imem_wren    : write strobe, one cycle after acceptance
//   imem_addr    : write word address
//   imem_data    : packed instruction word
//   busy         : FSM in LOAD or DONE
//   done         : pulse with the final write
//   err          : sticky error (illegal record or address overflow)
//   checksum     : XOR of words written since start (0 when disabled)
//   fsm_state    : current FSM state for observation
// ---------------------------------------------------------------------------
module instr_encoder_loader
   import cpu_isa_pkg::*;
#(
   parameter int ADDR_W    = 10,
   parameter int BASE_ADDR = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   instr_encoder_loader_if.slave rec,
   output logic                  imem_wren,
   output logic [ADDR_W-1:0]     imem_addr,
   output logic [31:0]           imem_data,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [31:0]           checksum,
   output load_state_t           fsm_state
);

   localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

   load_state_t       state, state_nxt;
   logic [ADDR_W-1:0] addr;
   logic              wrapped;
   logic [31:0]       word;
   logic              legal;
   logic              accept, write_ok, reject, start_go;

   instr_pack u_pack (
      .fmt   (fmt_t'(rec.in_fmt)),
      .op    (rec.in_op),
      .rs    (rec.in_rs),
      .rt    (rec.in_rt),
      .rd    (rec.in_rd),
      .shamt (rec.in_shamt),
      .funct (rec.in_funct),
      .imm   (rec.in_imm),
      .addr  (rec.in_addr),
      .word  (word),
      .legal (legal)
   );

   assign rec.in_ready = (state == ST_LOAD);
   assign accept       = rec.in_valid && rec.in_ready;
   // Once the top address has been written, any further record would
   // overwrite from the bottom; it is rejected instead.
   assign write_ok     = accept && legal && !wrapped;
   assign reject       = accept && (!legal || wrapped);
   assign start_go     = start && ((state == ST_IDLE) || (state == ST_ERR));

   assign busy      = (state == ST_LOAD) || (state == ST_DONE);
   assign fsm_state = state;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (start) state_nxt = ST_LOAD;
         ST_LOAD: begin
            if (reject)                        state_nxt = ST_ERR;
            else if (write_ok && rec.in_last)  state_nxt = ST_DONE;
         end
         ST_DONE: state_nxt = ST_IDLE;
         ST_ERR:  if (start) state_nxt = ST_LOAD;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Address counter, write port and status registers. done is registered
   // alongside imem_wren so it lines up with the final write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr      <= BASE;
         wrapped   <= 1'b0;
         imem_wren <= 1'b0;
         imem_addr <= '0;
         imem_data <= 32'h0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         imem_wren <= write_ok;
         done      <= write_ok && rec.in_last;
         if (write_ok) begin
            imem_addr <= addr;
            imem_data <= word;
            addr      <= addr + ADDR_W'(1);
            if (addr == {ADDR_W{1'b1}}) wrapped <= 1'b1;
         end
         if (start_go) begin
            addr    <= BASE;
            wrapped <= 1'b0;
            err     <= 1'b0;
         end else if (reject) begin
            err <= 1'b1;
         end
      end
   end

`ifdef ENC_CHECKSUM_EN
   // Accumulates the word being accepted so the checksum updates in the
   // same cycle the word appears on imem_data.
   logic [31:0] csum;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        csum <= 32'h0;
      else if (start_go) csum <= 32'h0;
      else if (write_ok) csum <= csum ^ word;
   end
   assign checksum = csum;
`else
   assign checksum = 32'h0;
`endif

endmodule

// File: tb/tb_instr_encoder_loader.sv
// ---------------------------------------------------------------------------
// tb_instr_encoder_loader
// Directed bench for instr_encoder_loader: a default-size instance
// (ADDR_W=10) and a small instance (ADDR_W=2) for address overflow.
// Inputs change on the falling edge; outputs are checked on the next
// falling edge, i.e. after the rising edge that consumed the inputs.
// ---------------------------------------------------------------------------
module tb_instr_encoder_loader;
   import cpu_isa_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic start_big = 1'b0;
   logic start_small = 1'b0;

   instr_encoder_loader_if big_if();
   instr_encoder_loader_if small_if();

   logic        b_wren, b_busy, b_done, b_err;
   logic [9:0]  b_addr;
   logic [31:0] b_data, b_csum;
   load_state_t b_state;

   logic        s_wren, s_busy, s_done, s_err;
   logic [1:0]  s_addr;
   logic [31:0] s_data, s_csum;
   load_state_t s_state;

   instr_encoder_loader #(.ADDR_W(10), .BASE_ADDR(0)) u_big (
      .clk(clk), .rst_n(rst_n), .start(start_big), .rec(big_if.slave),
      .imem_wren(b_wren), .imem_addr(b_addr), .imem_data(b_data),
      .busy(b_busy), .done(b_done), .err(b_err), .checksum(b_csum),
      .fsm_state(b_state)
   );

   instr_encoder_loader #(.ADDR_W(2), .BASE_ADDR(0)) u_small (
      .clk(clk), .rst_n(rst_n), .start(start_small), .rec(small_if.slave),
      .imem_wren(s_wren), .imem_addr(s_addr), .imem_data(s_data),
      .busy(s_busy), .done(s_done), .err(s_err), .checksum(s_csum),
      .fsm_state(s_state)
   );

   // ---------------- scoreboard ----------------
   int checks = 0;
   int failures = 0;
   logic [31:0] exp_q[$];
   logic [31:0] exp_csum;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   // Compare one big-instance write against the head of the expected queue.
   task automatic check_write(input string tag, input logic [31:0] exp_addr, input logic exp_done);
      logic [31:0] exp_word;
      exp_word = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      check({tag, "_wren"}, 32'(b_wren), 32'd1);
      check({tag, "_addr"}, 32'(b_addr), exp_addr);
      check({tag, "_data"}, b_data, exp_word);
      check({tag, "_done"}, 32'(b_done), 32'(exp_done));
   endtask

   // ---------------- drivers ----------------
   task automatic big_idle();
      big_if.in_valid = 1'b0;
      big_if.in_last  = 1'b0;
   endtask

   task automatic pulse_start_big();
      start_big = 1'b1;
      @(negedge clk);
      start_big = 1'b0;
   endtask

   // Unused fields are filled with random bits: they must not reach the word.
   task automatic rec_r(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] shamt, input logic [5:0] funct,
                        input logic last);
      big_if.in_fmt   = 2'd0;
      big_if.in_op    = op;
      big_if.in_rs    = rs;
      big_if.in_rt    = rt;
      big_if.in_rd    = rd;
      big_if.in_shamt = shamt;
      big_if.in_funct = funct;
      big_if.in_imm   = 16'($urandom_range(0, 16'hFFFF));
      big_if.in_addr  = 26'($urandom);
      big_if.in_last  = last;
      big_if.in_valid = 1'b1;
   endtask

   task automatic rec_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [15:0] imm, input logic last);
      big_if.in_fmt   = 2'd1;
      big_if.in_op    = op;
      big_if.in_rs    = rs;
      big_if.in_rt    = rt;
      big_if.in_rd    = 5'($urandom_range(0, 31));
      big_if.in_shamt = 5'($urandom_range(0, 31));
      big_if.in_funct = 6'($urandom_range(0, 63));
      big_if.in_imm   = imm;
      big_if.in_addr  = 26'($urandom);
      big_if.in_last  = last;
      big_if.in_valid = 1'b1;
   endtask

   task automatic rec_j(input logic [5:0] op, input logic [25:0] target, input logic last);
      big_if.in_fmt   = 2'd2;
      big_if.in_op    = op;
      big_if.in_rs    = 5'($urandom_range(0, 31));
      big_if.in_rt    = 5'($urandom_range(0, 31));
      big_if.in_rd    = 5'($urandom_range(0, 31));
      big_if.in_shamt = 5'($urandom_range(0, 31));
      big_if.in_funct = 6'($urandom_range(0, 63));
      big_if.in_imm   = 16'($urandom_range(0, 16'hFFFF));
      big_if.in_addr  = target;
      big_if.in_last  = last;
      big_if.in_valid = 1'b1;
   endtask

   // ADD rs=1 rt=2 rd=i for i=0..3
   logic [31:0] small_words [4];

   // ---------------- directed sequence ----------------
   initial begin
      small_words[0] = 32'h0022_0020;
      small_words[1] = 32'h0022_0820;
      small_words[2] = 32'h0022_1020;
      small_words[3] = 32'h0022_1820;

      big_if.in_valid = 1'b0; big_if.in_fmt = 2'd0; big_if.in_op = 6'h0;
      big_if.in_rs = 5'h0; big_if.in_rt = 5'h0; big_if.in_rd = 5'h0;
      big_if.in_shamt = 5'h0; big_if.in_funct = 6'h0; big_if.in_imm = 16'h0;
      big_if.in_addr = 26'h0; big_if.in_last = 1'b0;
      small_if.in_valid = 1'b0; small_if.in_fmt = 2'd0; small_if.in_op = 6'h0;
      small_if.in_rs = 5'd1; small_if.in_rt = 5'd2; small_if.in_rd = 5'h0;
      small_if.in_shamt = 5'h0; small_if.in_funct = FN_ADD; small_if.in_imm = 16'h0;
      small_if.in_addr = 26'h0; small_if.in_last = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_wren",  32'(b_wren), 32'd0);
      check("rst_addr",  32'(b_addr), 32'd0);
      check("rst_data",  b_data,      32'd0);
      check("rst_busy",  32'(b_busy), 32'd0);
      check("rst_done",  32'(b_done), 32'd0);
      check("rst_err",   32'(b_err),  32'd0);
      check("rst_csum",  b_csum,      32'd0);
      check("rst_ready", 32'(big_if.in_ready), 32'd0);
      check("rst_state", 32'(b_state), 32'(ST_IDLE));
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_ready", 32'(big_if.in_ready), 32'd0);

      // Single ADD as a one-word program
      pulse_start_big();
      check("load_ready", 32'(big_if.in_ready), 32'd1);
      check("load_busy",  32'(b_busy), 32'd1);
      rec_r(OP_SPECIAL, 5'd1, 5'd2, 5'd3, 5'd0, FN_ADD, 1'b1);
      exp_q.push_back(32'h0022_1820);
      @(negedge clk);
      big_idle();
      check_write("add", 32'd0, 1'b1);
      @(negedge clk);
      check("add_busy_after", 32'(b_busy), 32'd0);
      check("add_wren_after", 32'(b_wren), 32'd0);

      // Back-to-back ADDI then LW(last)
      pulse_start_big();
      rec_i(OP_ADDI, 5'd0, 5'd1, 16'd5, 1'b0);
      exp_q.push_back(32'h2001_0005);
      @(negedge clk);
      check_write("addi", 32'd0, 1'b0);
      rec_i(OP_LW, 5'd1, 5'd2, 16'd4, 1'b1);
      exp_q.push_back(32'h8C22_0004);
      @(negedge clk);
      big_idle();
      check_write("lw", 32'd1, 1'b1);
      check("lw_busy", 32'(b_busy), 32'd1);
      @(negedge clk);
      check("lw_busy_after", 32'(b_busy), 32'd0);
      check("lw_done_after", 32'(b_done), 32'd0);
`ifdef ENC_CHECKSUM_EN
      exp_csum = 32'hAC23_0001;
`else
      exp_csum = 32'h0;
`endif
      check("csum_two", b_csum, exp_csum);

      // J target
      pulse_start_big();
      rec_j(OP_J, 26'h010_0000, 1'b1);
      exp_q.push_back(32'h0810_0000);
      @(negedge clk);
      big_idle();
      check_write("j", 32'd0, 1'b1);
      @(negedge clk);

      // Illegal: R format with opcode 08
      pulse_start_big();
      rec_r(6'h08, 5'd1, 5'd2, 5'd3, 5'd0, FN_ADD, 1'b0);
      @(negedge clk);
      big_idle();
      check("bad_r_wren",  32'(b_wren), 32'd0);
      check("bad_r_err",   32'(b_err),  32'd1);
      check("bad_r_ready", 32'(big_if.in_ready), 32'd0);
      check("bad_r_state", 32'(b_state), 32'(ST_ERR));
      @(negedge clk);
      check("err_sticky", 32'(b_err), 32'd1);

      // Restart from ERR: err clears, address rewinds
      pulse_start_big();
      check("restart_err",   32'(b_err), 32'd0);
      check("restart_ready", 32'(big_if.in_ready), 32'd1);
      rec_i(OP_SW, 5'd2, 5'd3, 16'h0010, 1'b0);
      exp_q.push_back(32'hAC43_0010);
      @(negedge clk);
      big_idle();
      check_write("sw", 32'd0, 1'b0);
      // start is ignored while loading: address keeps counting
      pulse_start_big();
      rec_r(OP_SPECIAL, 5'd4, 5'd5, 5'd6, 5'd0, FN_SUB, 1'b0);
      exp_q.push_back(32'h0085_3022);
      @(negedge clk);
      big_idle();
      check_write("sub", 32'd1, 1'b0);
`ifdef ENC_CHECKSUM_EN
      exp_csum = 32'hACC6_3032;
`else
      exp_csum = 32'h0;
`endif
      check("csum_restart", b_csum, exp_csum);
      // fmt=3 is always illegal
      big_if.in_fmt = 2'd3; big_if.in_op = OP_ADDI; big_if.in_valid = 1'b1;
      @(negedge clk);
      big_idle();
      check("fmt3_wren", 32'(b_wren), 32'd0);
      check("fmt3_err",  32'(b_err),  32'd1);

      // I format with a J opcode is illegal
      pulse_start_big();
      rec_i(OP_JAL, 5'd1, 5'd1, 16'h1234, 1'b1);
      @(negedge clk);
      big_idle();
      check("i_jal_wren", 32'(b_wren), 32'd0);
      check("i_jal_err",  32'(b_err),  32'd1);
      check("i_jal_done", 32'(b_done), 32'd0);

      // Small instance: four writes fill 0..3, the fifth is rejected
      start_small = 1'b1;
      @(negedge clk);
      start_small = 1'b0;
      for (int i = 0; i < 5; i++) begin
         small_if.in_fmt   = 2'd0;
         small_if.in_op    = OP_SPECIAL;
         small_if.in_rd    = 5'(i % 4);
         small_if.in_last  = 1'b0;
         small_if.in_valid = 1'b1;
         @(negedge clk);
         if (i < 4) begin
            check($sformatf("wrap_wren%0d", i), 32'(s_wren), 32'd1);
            check($sformatf("wrap_addr%0d", i), 32'(s_addr), 32'(i));
            check($sformatf("wrap_data%0d", i), s_data, small_words[i]);
         end else begin
            check("wrap_fifth_wren", 32'(s_wren), 32'd0);
            check("wrap_fifth_err",  32'(s_err),  32'd1);
         end
      end
      small_if.in_valid = 1'b0;
      @(negedge clk);

      // Small instance: last on the top address is a normal completion
      start_small = 1'b1;
      @(negedge clk);
      start_small = 1'b0;
      check("top_err_cleared", 32'(s_err), 32'd0);
      for (int i = 0; i < 4; i++) begin
         small_if.in_rd    = 5'(i);
         small_if.in_last  = (i == 3);
         small_if.in_valid = 1'b1;
         @(negedge clk);
         check($sformatf("top_done%0d", i), 32'(s_done), 32'(i == 3));
      end
      small_if.in_valid = 1'b0;
      small_if.in_last  = 1'b0;
      check("top_addr", 32'(s_addr), 32'd3);
      check("top_err",  32'(s_err),  32'd0);
      @(negedge clk);
      check("top_busy_after", 32'(s_busy), 32'd0);

      // Asynchronous reset in the middle of a stream
      pulse_start_big();
      rec_r(OP_SPECIAL, 5'd1, 5'd2, 5'd3, 5'd0, FN_ADD, 1'b0);
      exp_q.push_back(32'h0022_1820);
      @(negedge clk);
      check_write("mid_add", 32'd0, 1'b0);
      rec_i(OP_ADDI, 5'd0, 5'd1, 16'd5, 1'b0);
      exp_q.push_back(32'h2001_0005);
      @(negedge clk);
      check_write("mid_addi", 32'd1, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_wren",  32'(b_wren), 32'd0);
      check("arst_addr",  32'(b_addr), 32'd0);
      check("arst_data",  b_data,      32'd0);
      check("arst_busy",  32'(b_busy), 32'd0);
      check("arst_done",  32'(b_done), 32'd0);
      check("arst_err",   32'(b_err),  32'd0);
      check("arst_csum",  b_csum,      32'd0);
      check("arst_ready", 32'(big_if.in_ready), 32'd0);
      @(negedge clk);
      check("arst_hold_wren", 32'(b_wren), 32'd0);
      big_idle();
      rst_n = 1'b1;
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "time limit reached");
   end

endmodule
